player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
- Sits directly upstream of the player sprite/missile block in the VGA peripheral.
- Converts raw left/right/fire pushbuttons into two outputs that the player block consumes: the player sprite column (btn_col) and the per-slot missile toggle vector (btn_missle_en).
- Debounces the buttons, moves the player at a fixed tick rate with screen clamping, and launches at most one missile per fire event into the lowest free slot, subject to a cooldown.

Parameters:
- COL_INIT, 305, player column after reset
- COL_MIN, 0, leftmost legal player column
- COL_MAX, 609, rightmost legal column (640 minus 31-pixel sprite width)
- STEP, 2, pixels moved per move tick
- MOVE_DIV, 250000, clk cycles per move tick (tick period = MOVE_DIV cycles)
- DB_CYC, 315000, cycles a synchronized input must be stable before it is accepted (about 10 ms at 31.5 MHz)
- COOLDOWN_TICKS, 8, move ticks after a launch before another launch is allowed
- NUM_SLOTS, 8, number of missile slots

Ports:
- clk  in  1  system clock (31.5 MHz pixel clock domain)
- rst  in  1  synchronous, active-high reset
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- btn_fire  in  1  raw asynchronous button
- slot_busy  in  NUM_SLOTS  per-slot in-flight flag, equal to btn_missle_en XOR the player block's internal enable
- btn_col  out  12  player column, to the player block
- btn_missle_en  out  NUM_SLOTS  toggle vector, to the player block
- fire_pulse  out  1  one-cycle strobe on each launch (for the sound/score blocks)
- move_tick  out  1  one-cycle strobe at each move tick

Behaviour:
- Reset values: btn_col=COL_INIT, btn_missle_en=0, fire_pulse=0, move_tick=0. Reset also clears all synchronizers, debouncers, the tick counter and the cooldown counter, and puts the fire FSM in IDLE.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DB_CYC consecutive cycles in which the synchronized value differs from the current debounced level.
  - Any bounce restarts the count.
  - Latency from a clean edge to the debounced edge is 2+DB_CYC cycles.
- Move tick:
  - The counter runs 0..MOVE_DIV-1. move_tick is asserted in the cycle the counter wraps.
- Movement, evaluated only on move_tick:
  - left=1 and right=0: btn_col = max(btn_col-STEP, COL_MIN).
  - right=1 and left=0: btn_col = min(btn_col+STEP, COL_MAX).
  - Both or neither pressed: hold.
  - Arithmetic uses 13 bits so the subtraction cannot underflow past 0.
  - btn_col updates in the cycle after move_tick.
- Fire FSM, states IDLE, COOLDOWN:
  - Launch condition: IDLE and a fire request and slot_busy not all ones. The fire request is the debounced rising edge of btn_fire.
  - On launch:
    - Choose the lowest index i with slot_busy[i]=0 and toggle btn_missle_en[i].
    - Assert fire_pulse for one cycle.
    - Load the cooldown counter with COOLDOWN_TICKS and enter COOLDOWN.
  - If all slots are busy, the request is dropped, not queued. The FSM stays in IDLE.
  - A request arriving while in COOLDOWN is dropped.
  - COOLDOWN: decrement the counter on each move_tick. When it reaches 0, return to IDLE.
  - Launch and a move_tick in the same cycle: both take effect, and the cooldown decrement begins at the next tick.
- Slot ownership:
  - btn_missle_en is toggled only by this block. The player block clears slot_busy by toggling its own enable.
  - This block never toggles a slot whose slot_busy=1.
  - slot_busy is sampled in the launch cycle only.
- Launch timing: the launch takes effect at the player block's next motion update. This block does not gate on the player block's timing.

Optional Feature:
- Macro: PLAYER_AUTOFIRE_EN.
- Defined: while debounced btn_fire stays high, a new fire request is generated each time the FSM returns to IDLE. Repeat rate = one launch per COOLDOWN_TICKS+1 move ticks, subject to free slots.
- Undefined: exactly one request per debounced rising edge. Holding the button produces no further launches.

Decomposition:
- Package spaceinv_pkg holds:
  - SCREEN_W=640, PLAYER_W=31
  - NUM_SLOTS=8
  - COL_W=12
  - typedef fire_state_t {IDLE, COOLDOWN}
- Sub-module btn_debounce (synchronizer plus debounce counter, parameter DB_CYC), instantiated three times.
- Lowest-free-slot priority encoder is a function in the package.

Test Plan (bench overrides DB_CYC=4, MOVE_DIV=10):
1. Reset, then hold right 400 ticks -> btn_col steps 305, 307, …, saturates at 609 and holds. Then hold left -> descends to 0 and holds; never wraps to 4095.
2. btn_fire glitch of 3 cycles -> no fire_pulse. Clean press of 10 cycles -> exactly one fire_pulse; btn_missle_en goes 0x00→0x01.
3. slot_busy=0x07, press fire -> btn_missle_en bit 3 toggles (0x01→0x09). With slot_busy=0xFF -> no pulse, btn_missle_en unchanged.
4. Two presses 3 ticks apart with COOLDOWN_TICKS=8 -> second is dropped. A press at tick 9 after the launch is accepted.
5. Left and right held together for 20 ticks -> btn_col unchanged. Assert rst mid-COOLDOWN with btn_col=411 -> next cycle btn_col=305, btn_missle_en=0, and an immediate clean press is accepted.
6. PLAYER_AUTOFIRE_EN defined, fire held 50 ticks, slot_busy=0 -> fire_pulse every 9 ticks (6 pulses). Undefined -> exactly 1 pulse.

Source files
------------

// File: rtl/spaceinv_pkg.sv
// Shared screen geometry, slot count, fire FSM state type and the
// lowest-free-slot priority encoder for the space-invaders VGA peripheral.
package spaceinv_pkg;

  localparam int SCREEN_W  = 640;
  localparam int PLAYER_W  = 31;
  localparam int NUM_SLOTS = 8;
  localparam int COL_W     = 12;

  typedef enum logic {
    IDLE,
    COOLDOWN
  } fire_state_t;

  // One-hot mask of the lowest slot whose busy flag is clear; all zeros when every slot is busy.
  function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
    logic [NUM_SLOTS-1:0] sel;
    sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) sel = NUM_SLOTS'(1) << i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/player_input_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level
// follows the synchronized input only after DB_CYC consecutive differing cycles.
module btn_debounce #(
  parameter int DB_CYC = 315000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);
  localparam int CNT_W = $clog2(DB_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYC - 1)) level_d = sync2_q;
      else                             cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, which is
  // what makes sync1_q -> sync2_q a real two-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Player input controller: debounced buttons -> clamped player column and missile slot toggles.
// Build option: define PLAYER_AUTOFIRE_EN to keep launching while fire is held.
module player_input_ctrl
  import spaceinv_pkg::*;
#(
  parameter int COL_INIT       = 305,
  parameter int COL_MIN        = 0,
  parameter int COL_MAX        = SCREEN_W - PLAYER_W,
  parameter int STEP           = 2,
  parameter int MOVE_DIV       = 250000,
  parameter int DB_CYC         = 315000,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_fire,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [COL_W-1:0]     btn_col,
  output logic [NUM_SLOTS-1:0] btn_missle_en,
  output logic                 fire_pulse,
  output logic                 move_tick
);
  localparam int TICK_W = $clog2(MOVE_DIV);
  localparam int CD_W   = $clog2(COOLDOWN_TICKS + 1);
  localparam int EXT_W  = COL_W + 1;

  logic left_db, right_db, fire_db;

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_left  (.clk(clk), .rst(rst), .btn_i(btn_left),  .level_o(left_db));
  btn_debounce #(.DB_CYC(DB_CYC)) u_db_right (.clk(clk), .rst(rst), .btn_i(btn_right), .level_o(right_db));
  btn_debounce #(.DB_CYC(DB_CYC)) u_db_fire  (.clk(clk), .rst(rst), .btn_i(btn_fire),  .level_o(fire_db));

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick_wrap;

  always_comb begin
    tick_wrap = (tick_q == TICK_W'(MOVE_DIV - 1));
    tick_d    = tick_wrap ? '0 : tick_q + TICK_W'(1);
  end

  // Column arithmetic is one bit wider so a step below COL_MIN shows up as a compare, not a wrap.
  logic [COL_W-1:0] col_q, col_d;
  logic [EXT_W-1:0] col_ext, col_dec, col_inc;

  always_comb begin
    col_ext = {1'b0, col_q};
    col_dec = col_ext - EXT_W'(STEP);
    col_inc = col_ext + EXT_W'(STEP);
    col_d   = col_q;
    if (tick_wrap) begin
      if (left_db && !right_db) begin
        col_d = (col_ext < EXT_W'(COL_MIN + STEP)) ? COL_W'(COL_MIN) : col_dec[COL_W-1:0];
      end else if (right_db && !left_db) begin
        col_d = (col_inc > EXT_W'(COL_MAX)) ? COL_W'(COL_MAX) : col_inc[COL_W-1:0];
      end
    end
  end

  logic fire_req;
`ifdef PLAYER_AUTOFIRE_EN
  // A held button is a standing request, honoured each time the FSM is back in IDLE.
  assign fire_req = fire_db;
`else
  logic fire_db_q;
  always_ff @(posedge clk) begin
    if (rst) fire_db_q <= 1'b0;
    else     fire_db_q <= fire_db;
  end
  assign fire_req = fire_db & ~fire_db_q;
`endif

  fire_state_t          state_q, state_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [NUM_SLOTS-1:0] en_q, en_d;
  logic [NUM_SLOTS-1:0] free_sel;
  logic                 launch;
  logic                 pulse_q;

  // A launch in a tick cycle does not count that tick toward the cooldown.
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    en_d     = en_q;
    launch   = 1'b0;
    free_sel = lowest_free(slot_busy);
    unique case (state_q)
      IDLE: begin
        if (fire_req && !(&slot_busy)) begin
          launch  = 1'b1;
          en_d    = en_q ^ free_sel;
          cd_d    = CD_W'(COOLDOWN_TICKS);
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (tick_wrap) begin
          if (cd_q == '0) state_d = IDLE;
          else            cd_d    = cd_q - CD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      col_q   <= COL_W'(COL_INIT);
      state_q <= IDLE;
      cd_q    <= '0;
      en_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      col_q   <= col_d;
      state_q <= state_d;
      cd_q    <= cd_d;
      en_q    <= en_d;
      pulse_q <= launch;
    end
  end

  assign btn_col       = col_q;
  assign btn_missle_en = en_q;
  assign fire_pulse    = pulse_q;
  assign move_tick     = tick_wrap;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with DB_CYC=4, MOVE_DIV=10; expected
// values are hand-derived from the column/slot rules.
module tb_player_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_left, btn_right, btn_fire;
  logic [7:0]  slot_busy;
  logic [11:0] btn_col;
  logic [7:0]  btn_missle_en;
  logic        fire_pulse, move_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  player_input_ctrl #(.DB_CYC(4), .MOVE_DIV(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_fire     (btn_fire),
    .slot_busy    (slot_busy),
    .btn_col      (btn_col),
    .btn_missle_en(btn_missle_en),
    .fire_pulse   (fire_pulse),
    .move_tick    (move_tick)
  );

  always @(posedge clk) if (fire_pulse === 1'b1) pulses <= pulses + 1;

  // Returns at the negedge of the next cycle in which move_tick is high.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (move_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (move_tick !== 1'b1) $display("FAIL tick_timeout: move_tick=%b after %0d cycles, want 1", move_tick, n);
    else n_pass++;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic press_fire(input int len);
    btn_fire = 1'b1;
    repeat (len) @(negedge clk);
    btn_fire = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; slot_busy = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (btn_col !== 12'd305) $display("FAIL reset_col: got %0d want 305", btn_col); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h00) $display("FAIL reset_en: got %h want 00", btn_missle_en); else n_pass++;
    n_checks++; if (fire_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", fire_pulse); else n_pass++;
    n_checks++; if (move_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", move_tick); else n_pass++;
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (move_tick !== 1'b1 && n < 40);
    n_checks++; if (n !== 9) $display("FAIL first_tick: after %0d cycles want 9", n); else n_pass++;
    n = 0;
    do begin @(negedge clk); n++; end while (move_tick !== 1'b1 && n < 40);
    n_checks++; if (n !== 10) $display("FAIL tick_period: %0d cycles want 10", n); else n_pass++;
  endtask

  task automatic test_movement();
    int n_bad, bad_k, bad_v, bad_e, expv;
    n_bad = 0; bad_k = 0; bad_v = 0; bad_e = 0;
    wait_tick();
    btn_right = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      wait_tick(); @(negedge clk);
      expv = 305 + 2 * k;
      if (expv > 609) expv = 609;
      if (btn_col !== 12'(expv)) begin
        if (n_bad == 0) begin bad_k = k; bad_v = int'(btn_col); bad_e = expv; end
        n_bad++;
      end
    end
    n_checks++;
    if (n_bad !== 0) $display("FAIL ramp_right: tick %0d btn_col=%0d want %0d (%0d bad)", bad_k, bad_v, bad_e, n_bad);
    else n_pass++;
    n_checks++; if (btn_col !== 12'd609) $display("FAIL clamp_max: got %0d want 609", btn_col); else n_pass++;

    n_bad = 0;
    wait_tick();
    btn_right = 1'b0; btn_left = 1'b1;
    for (int k = 1; k <= 320; k++) begin
      wait_tick(); @(negedge clk);
      expv = 609 - 2 * k;
      if (expv < 0) expv = 0;
      if (btn_col !== 12'(expv)) begin
        if (n_bad == 0) begin bad_k = k; bad_v = int'(btn_col); bad_e = expv; end
        n_bad++;
      end
    end
    n_checks++;
    if (n_bad !== 0) $display("FAIL ramp_left: tick %0d btn_col=%0d want %0d (%0d bad)", bad_k, bad_v, bad_e, n_bad);
    else n_pass++;
    n_checks++; if (btn_col !== 12'd0) $display("FAIL clamp_min: got %0d want 0", btn_col); else n_pass++;
    btn_left = 1'b0;
  endtask

  task automatic test_fire_debounce();
    int base;
    slot_busy = 8'h00;
    base = pulses;
    press_fire(3);
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base !== 0) $display("FAIL glitch_pulses: got %0d want 0", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h00) $display("FAIL glitch_en: got %h want 00", btn_missle_en); else n_pass++;
    press_fire(10);
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base !== 1) $display("FAIL press_pulses: got %0d want 1", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h01) $display("FAIL press_en: got %h want 01", btn_missle_en); else n_pass++;
  endtask

  task automatic test_slot_select();
    int base;
    wait_ticks(10);
    slot_busy = 8'h07;
    base = pulses;
    press_fire(10);
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base !== 1) $display("FAIL slot3_pulses: got %0d want 1", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h09) $display("FAIL slot3_en: got %h want 09", btn_missle_en); else n_pass++;
    wait_ticks(10);
    slot_busy = 8'hFF;
    base = pulses;
    press_fire(10);
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base !== 0) $display("FAIL allbusy_pulses: got %0d want 0", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h09) $display("FAIL allbusy_en: got %h want 09", btn_missle_en); else n_pass++;
  endtask

  task automatic test_cooldown();
    int base;
    slot_busy = 8'h00;
    base = pulses;
    wait_tick();                  // T0: launch lands before T1
    press_fire(5);
    wait_tick(); @(negedge clk);  // T1
    n_checks++; if (pulses - base !== 1) $display("FAIL cd_first_pulses: got %0d want 1", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h08) $display("FAIL cd_first_en: got %h want 08", btn_missle_en); else n_pass++;
    wait_ticks(2);                // T3
    press_fire(5);
    wait_tick(); @(negedge clk);  // T4
    n_checks++; if (pulses - base !== 1) $display("FAIL cd_drop_pulses: got %0d want 1", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h08) $display("FAIL cd_drop_en: got %h want 08", btn_missle_en); else n_pass++;
    wait_ticks(5);                // T9
    press_fire(5);
    wait_tick(); @(negedge clk);  // T10
    n_checks++; if (pulses - base !== 2) $display("FAIL cd_t9_pulses: got %0d want 2", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h09) $display("FAIL cd_t9_en: got %h want 09", btn_missle_en); else n_pass++;
  endtask

  task automatic test_autofire();
    int base, expv;
`ifdef PLAYER_AUTOFIRE_EN
    expv = 6;
`else
    expv = 1;
`endif
    wait_ticks(10);
    slot_busy = 8'h00;
    base = pulses;
    wait_tick();
    btn_fire = 1'b1;
    wait_ticks(50);
    btn_fire = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (pulses - base !== expv) $display("FAIL hold_pulses: got %0d want %0d", pulses - base, expv); else n_pass++;
  endtask

  task automatic test_both_and_reset();
    int base, n_bad, bad_v;
    n_bad = 0; bad_v = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_tick();
    btn_right = 1'b1;
    wait_ticks(52);
    wait_tick();                  // tick 53 still moves right: 305 + 106
    btn_left = 1'b1;
    @(negedge clk);
    n_checks++; if (btn_col !== 12'd411) $display("FAIL col_411: got %0d want 411", btn_col); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      wait_tick(); @(negedge clk);
      if (btn_col !== 12'd411) begin
        if (n_bad == 0) bad_v = int'(btn_col);
        n_bad++;
      end
    end
    n_checks++;
    if (n_bad !== 0) $display("FAIL both_hold: btn_col=%0d want 411 (%0d bad)", bad_v, n_bad);
    else n_pass++;
    base = pulses;
    press_fire(5);
    repeat (10) @(negedge clk);
    n_checks++; if (btn_missle_en !== 8'h01) $display("FAIL pre_rst_en: got %h want 01", btn_missle_en); else n_pass++;
    btn_left = 1'b0; btn_right = 1'b0;
    wait_ticks(2);
    n_checks++; if (btn_col !== 12'd411) $display("FAIL pre_rst_col: got %0d want 411", btn_col); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (btn_col !== 12'd305) $display("FAIL mid_rst_col: got %0d want 305", btn_col); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h00) $display("FAIL mid_rst_en: got %h want 00", btn_missle_en); else n_pass++;
    rst = 1'b0;
    base = pulses;
    press_fire(10);
    repeat (10) @(negedge clk);
    n_checks++; if (pulses - base !== 1) $display("FAIL post_rst_pulses: got %0d want 1", pulses - base); else n_pass++;
    n_checks++; if (btn_missle_en !== 8'h01) $display("FAIL post_rst_en: got %h want 01", btn_missle_en); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_movement();
    test_fire_debounce();
    test_slot_select();
    test_cooldown();
    test_autofire();
    test_both_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
